// File: rtl/hsv_blob_pkg.sv
// Shared types, default widths and the HSV window match used by the blob tracker.
package hsv_blob_pkg;

    typedef enum logic [2:0] {
        ACCUM,
        CHECK,
        DIV_X,
        DIV_Y,
        REPORT
    } blob_state_e;

    localparam int X_WIDTH_DEF = 10;
    localparam int Y_WIDTH_DEF = 10;
    localparam int CNT_W_DEF   = X_WIDTH_DEF + Y_WIDTH_DEF;
    localparam int DIV_W_DEF   = CNT_W_DEF + ((X_WIDTH_DEF > Y_WIDTH_DEF) ? X_WIDTH_DEF : Y_WIDTH_DEF);

    // A window with h_lo > h_hi wraps through red (255 -> 0).
    function automatic logic hsv_match(
        input logic [7:0] h,
        input logic [7:0] s,
        input logic [7:0] v,
        input logic [7:0] h_lo,
        input logic [7:0] h_hi,
        input logic [7:0] s_min,
        input logic [7:0] v_min
    );
        logic hue_ok;
        if (h_lo <= h_hi) hue_ok = (h >= h_lo) && (h <= h_hi);
        else              hue_ok = (h >= h_lo) || (h <= h_hi);
        return hue_ok && (s >= s_min) && (v >= v_min);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses W+1 cycles after start.
module seq_divider #(
    parameter int W = 30
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q, done_q;
    logic [W:0]    shifted, diff;

    // diff[W] set means the trial subtraction borrowed, so the remainder is restored.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= CW'(W);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
                quo_q <= {quo_q[W-2:0], ~diff[W]};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/hsv_blob_tracker.sv
// Per-frame HSV blob tracker: accumulates matching pixels, divides sums for the centroid.
// Optional bounding box tracking is enabled with `define HSV_BLOB_BBOX_EN.
module hsv_blob_tracker
    import hsv_blob_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIDTH = Y_WIDTH_DEF,
    parameter int CNT_W   = X_WIDTH + Y_WIDTH,
    parameter int DIV_W   = CNT_W + ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [7:0]         h,
    input  logic [7:0]         s,
    input  logic [7:0]         v,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               frame_end,
    input  logic [7:0]         h_lo,
    input  logic [7:0]         h_hi,
    input  logic [7:0]         s_min,
    input  logic [7:0]         v_min,
    input  logic [CNT_W-1:0]   min_count,
    output logic [X_WIDTH-1:0] cx,
    output logic [Y_WIDTH-1:0] cy,
    output logic [CNT_W-1:0]   count,
    output logic               found,
    output logic               result_valid,
    output logic               busy,
    output logic               overrun,
    output logic [X_WIDTH-1:0] bx_min,
    output logic [X_WIDTH-1:0] bx_max,
    output logic [Y_WIDTH-1:0] by_min,
    output logic [Y_WIDTH-1:0] by_max
);

    blob_state_e        state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, snap_cnt_q, cnt_sum, count_q;
    logic [DIV_W-1:0]   acc_sx_q, acc_sy_q, snap_sx_q, snap_sy_q, sx_sum, sy_sum;
    logic [X_WIDTH-1:0] cx_q, qx_q;
    logic [Y_WIDTH-1:0] cy_q;
    logic               found_q, overrun_q;
    logic               pix_hit, busy_w, skip_w;
    logic               div_start, div_done;
    logic [DIV_W-1:0]   div_dividend, div_divisor, div_quotient;
    logic               unused_quo;

    assign pix_hit      = pix_valid && hsv_match(h, s, v, h_lo, h_hi, s_min, v_min);
    assign busy_w       = (state_q != ACCUM);
    assign skip_w       = (snap_cnt_q == '0) || (snap_cnt_q < min_count);
    assign div_dividend = (state_q == CHECK) ? snap_sx_q : snap_sy_q;
    assign div_divisor  = DIV_W'(snap_cnt_q);
    assign unused_quo   = ^div_quotient;

    always_comb begin
        cnt_sum = acc_cnt_q;
        sx_sum  = acc_sx_q;
        sy_sum  = acc_sy_q;
        if (pix_hit) begin
            cnt_sum = acc_cnt_q + CNT_W'(1);
            sx_sum  = acc_sx_q + DIV_W'(x);
            sy_sum  = acc_sy_q + DIV_W'(y);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // The shared divider handles x first, then is restarted for y on the x done pulse.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ACCUM:  if (frame_end) state_d = CHECK;
            CHECK: begin
                if (skip_w) begin
                    state_d = REPORT;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV_X;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    div_start = 1'b1;
                    state_d   = DIV_Y;
                end
            end
            DIV_Y:  if (div_done) state_d = REPORT;
            REPORT: state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    seq_divider #(.W(DIV_W)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_cnt_q  <= '0;
            acc_sx_q   <= '0;
            acc_sy_q   <= '0;
            snap_cnt_q <= '0;
            snap_sx_q  <= '0;
            snap_sy_q  <= '0;
            qx_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            count_q    <= '0;
            found_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // The pixel arriving with frame_end is folded into the closing snapshot.
            if (frame_end) begin
                acc_cnt_q <= '0;
                acc_sx_q  <= '0;
                acc_sy_q  <= '0;
                if (!busy_w) begin
                    snap_cnt_q <= cnt_sum;
                    snap_sx_q  <= sx_sum;
                    snap_sy_q  <= sy_sum;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                acc_cnt_q <= cnt_sum;
                acc_sx_q  <= sx_sum;
                acc_sy_q  <= sy_sum;
            end

            if (state_q == DIV_X && div_done) qx_q <= div_quotient[X_WIDTH-1:0];

            if (state_q == CHECK && skip_w) begin
                cx_q    <= '0;
                cy_q    <= '0;
                count_q <= snap_cnt_q;
                found_q <= 1'b0;
            end else if (state_q == DIV_Y && div_done) begin
                cx_q    <= qx_q;
                cy_q    <= div_quotient[Y_WIDTH-1:0];
                count_q <= snap_cnt_q;
                found_q <= 1'b1;
            end
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign count        = count_q;
    assign found        = found_q;
    assign overrun      = overrun_q;
    assign busy         = busy_w;
    assign result_valid = (state_q == REPORT);

`ifdef HSV_BLOB_BBOX_EN
    logic [X_WIDTH-1:0] acc_xmin_q, acc_xmax_q, snap_xmin_q, snap_xmax_q, bx_min_q, bx_max_q;
    logic [X_WIDTH-1:0] xmin_upd, xmax_upd;
    logic [Y_WIDTH-1:0] acc_ymin_q, acc_ymax_q, snap_ymin_q, snap_ymax_q, by_min_q, by_max_q;
    logic [Y_WIDTH-1:0] ymin_upd, ymax_upd;

    // An empty accumulator takes the first matching pixel as both min and max.
    always_comb begin
        xmin_upd = acc_xmin_q;
        xmax_upd = acc_xmax_q;
        ymin_upd = acc_ymin_q;
        ymax_upd = acc_ymax_q;
        if (pix_hit) begin
            if (acc_cnt_q == '0 || x < acc_xmin_q) xmin_upd = x;
            if (acc_cnt_q == '0 || x > acc_xmax_q) xmax_upd = x;
            if (acc_cnt_q == '0 || y < acc_ymin_q) ymin_upd = y;
            if (acc_cnt_q == '0 || y > acc_ymax_q) ymax_upd = y;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_xmin_q  <= '0;
            acc_xmax_q  <= '0;
            acc_ymin_q  <= '0;
            acc_ymax_q  <= '0;
            snap_xmin_q <= '0;
            snap_xmax_q <= '0;
            snap_ymin_q <= '0;
            snap_ymax_q <= '0;
            bx_min_q    <= '0;
            bx_max_q    <= '0;
            by_min_q    <= '0;
            by_max_q    <= '0;
        end else begin
            if (frame_end) begin
                acc_xmin_q <= '0;
                acc_xmax_q <= '0;
                acc_ymin_q <= '0;
                acc_ymax_q <= '0;
                if (!busy_w) begin
                    snap_xmin_q <= xmin_upd;
                    snap_xmax_q <= xmax_upd;
                    snap_ymin_q <= ymin_upd;
                    snap_ymax_q <= ymax_upd;
                end
            end else begin
                acc_xmin_q <= xmin_upd;
                acc_xmax_q <= xmax_upd;
                acc_ymin_q <= ymin_upd;
                acc_ymax_q <= ymax_upd;
            end

            if (state_q == CHECK && skip_w) begin
                bx_min_q <= '0;
                bx_max_q <= '0;
                by_min_q <= '0;
                by_max_q <= '0;
            end else if (state_q == DIV_Y && div_done) begin
                bx_min_q <= snap_xmin_q;
                bx_max_q <= snap_xmax_q;
                by_min_q <= snap_ymin_q;
                by_max_q <= snap_ymax_q;
            end
        end
    end

    assign bx_min = bx_min_q;
    assign bx_max = bx_max_q;
    assign by_min = by_min_q;
    assign by_max = by_max_q;
`else
    assign bx_min = '0;
    assign bx_max = '0;
    assign by_min = '0;
    assign by_max = '0;
`endif

endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Randomised and directed bench for hsv_blob_tracker against a frame-level reference model.
module tb_hsv_blob_tracker;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int CW = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pix_valid = 1'b0;
    logic          frame_end = 1'b0;
    logic [7:0]    h = '0, s = '0, v = '0;
    logic [7:0]    h_lo = '0, h_hi = '0, s_min = '0, v_min = '0;
    logic [XW-1:0] x = '0;
    logic [YW-1:0] y = '0;
    logic [CW-1:0] min_count = '0;

    logic [XW-1:0] cx, bx_min, bx_max;
    logic [YW-1:0] cy, by_min, by_max;
    logic [CW-1:0] count;
    logic          found, result_valid, busy, overrun;

    hsv_blob_tracker dut (
        .clock        (clock),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .h            (h),
        .s            (s),
        .v            (v),
        .x            (x),
        .y            (y),
        .frame_end    (frame_end),
        .h_lo         (h_lo),
        .h_hi         (h_hi),
        .s_min        (s_min),
        .v_min        (v_min),
        .min_count    (min_count),
        .cx           (cx),
        .cy           (cy),
        .count        (count),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun),
        .bx_min       (bx_min),
        .bx_max       (bx_max),
        .by_min       (by_min),
        .by_max       (by_max)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges++;

    typedef struct {
        int e;
        int cx;
        int cy;
        int cnt;
        int found;
        int bx0;
        int bx1;
        int by0;
        int by1;
    } res_t;

    typedef struct {
        int h;
        int s;
        int v;
        int x;
        int y;
    } pix_t;

    res_t rq[$];
    res_t last_r;
    pix_t pq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always @(negedge clock) begin : mon
        res_t r;
        if (result_valid === 1'b1) begin
            r.e     = edges;
            r.cx    = int'(cx);
            r.cy    = int'(cy);
            r.cnt   = int'(count);
            r.found = int'(found);
            r.bx0   = int'(bx_min);
            r.bx1   = int'(bx_max);
            r.by0   = int'(by_min);
            r.by1   = int'(by_max);
            rq.push_back(r);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input int hh, input int ss, input int vv);
        int lo, hi;
        bit hue;
        lo = int'(h_lo);
        hi = int'(h_hi);
        if (lo <= hi) hue = (hh >= lo) && (hh <= hi);
        else          hue = !((hh > hi) && (hh < lo));
        return hue && (ss >= int'(s_min)) && (vv >= int'(v_min));
    endfunction

    // Expected report for the pixels currently in pq; e holds the frame_end-to-report latency.
    task automatic model(output res_t ex);
        longint cnt, sx, sy;
        int     x0, x1, y0, y1;
        bit     fnd;
        cnt = 0; sx = 0; sy = 0;
        x0 = 1 << 20; x1 = -1; y0 = 1 << 20; y1 = -1;
        foreach (pq[i]) begin
            if (in_win(pq[i].h, pq[i].s, pq[i].v)) begin
                cnt++;
                sx += pq[i].x;
                sy += pq[i].y;
                if (pq[i].x < x0) x0 = pq[i].x;
                if (pq[i].x > x1) x1 = pq[i].x;
                if (pq[i].y < y0) y0 = pq[i].y;
                if (pq[i].y > y1) y1 = pq[i].y;
            end
        end
        fnd      = (cnt > 0) && (cnt >= longint'(min_count));
        ex.e     = fnd ? 63 : 1;
        ex.cnt   = int'(cnt);
        ex.found = fnd ? 1 : 0;
        ex.cx    = fnd ? int'(sx / cnt) : 0;
        ex.cy    = fnd ? int'(sy / cnt) : 0;
        ex.bx0   = fnd ? x0 : 0;
        ex.bx1   = fnd ? x1 : 0;
        ex.by0   = fnd ? y0 : 0;
        ex.by1   = fnd ? y1 : 0;
    endtask

    task automatic add_pix(input int hh, input int ss, input int vv, input int xx, input int yy);
        pix_t p;
        p.h = hh; p.s = ss; p.v = vv; p.x = xx; p.y = yy;
        pq.push_back(p);
    endtask

    task automatic set_win(input int lo, input int hi, input int sm, input int vm, input int mc);
        h_lo = 8'(lo); h_hi = 8'(hi); s_min = 8'(sm); v_min = 8'(vm); min_count = CW'(mc);
    endtask

    // Last pixel of the queue is driven in the same cycle as frame_end.
    task automatic send_frame(input bit gaps, output int fe);
        fe = 0;
        if (pq.size() == 0) begin
            @(negedge clock);
            pix_valid = 1'b0;
            frame_end = 1'b1;
            fe = edges + 1;
        end else begin
            foreach (pq[i]) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clock);
                        pix_valid = 1'b0;
                        frame_end = 1'b0;
                        h = 8'($urandom); s = 8'($urandom); v = 8'($urandom);
                        x = XW'($urandom); y = YW'($urandom);
                    end
                end
                @(negedge clock);
                pix_valid = 1'b1;
                h = 8'(pq[i].h); s = 8'(pq[i].s); v = 8'(pq[i].v);
                x = XW'(pq[i].x); y = YW'(pq[i].y);
                frame_end = (i == pq.size() - 1);
                if (frame_end) fe = edges + 1;
            end
        end
        @(negedge clock);
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic check_result(input string tag, input int fe, input res_t ex);
        int   w;
        res_t r;
        w = 0;
        while (rq.size() == 0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (rq.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        r = rq.pop_front();
        last_r = r;
        $display("%s: lat=%0d count=%0d found=%0d cx=%0d cy=%0d", tag, r.e - fe, r.cnt, r.found, r.cx, r.cy);
        chk({tag, "_lat"},   r.e - fe, ex.e);
        chk({tag, "_count"}, r.cnt,    ex.cnt);
        chk({tag, "_found"}, r.found,  ex.found);
        chk({tag, "_cx"},    r.cx,     ex.cx);
        chk({tag, "_cy"},    r.cy,     ex.cy);
`ifdef HSV_BLOB_BBOX_EN
        chk({tag, "_bxmin"}, r.bx0, ex.bx0);
        chk({tag, "_bxmax"}, r.bx1, ex.bx1);
        chk({tag, "_bymin"}, r.by0, ex.by0);
        chk({tag, "_bymax"}, r.by1, ex.by1);
`else
        chk({tag, "_bbox0"}, r.bx0 | r.bx1 | r.by0 | r.by1, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t ex, ex_a;
        int   fe, fe_a;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_count", count, 0);
        chk("rst_found", found, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Square of four pixels; the last one rides on frame_end.
        set_win(80, 90, 50, 50, 1);
        pq.delete();
        add_pix(85, 100, 100, 10, 20);
        add_pix(85, 100, 100, 12, 20);
        add_pix(85, 100, 100, 10, 24);
        add_pix(85, 100, 100, 12, 24);
        model(ex);
        send_frame(1'b0, fe);
        chk("t1_busy", busy, 1);
        check_result("t1", fe, ex);
        chk("t1_cx_const", last_r.cx, 11);
        chk("t1_cy_const", last_r.cy, 22);
        chk("t1_cnt_const", last_r.cnt, 4);
        chk("t1_busy_after", busy, 0);

        set_win(240, 10, 0, 0, 1);
        pq.delete();
        add_pix(250, 255, 255, 100, 100);
        add_pix(5, 255, 255, 200, 50);
        add_pix(128, 255, 255, 300, 300);
        model(ex);
        send_frame(1'b1, fe);
        check_result("wrap", fe, ex);
        chk("wrap_cnt_const", last_r.cnt, 2);

        set_win(80, 90, 50, 50, 1);
        pq.delete();
        add_pix(10, 200, 200, 5, 5);
        add_pix(91, 200, 200, 6, 6);
        add_pix(85, 49, 200, 7, 7);
        model(ex);
        send_frame(1'b1, fe);
        check_result("nomatch", fe, ex);

        set_win(80, 90, 50, 50, 5);
        pq.delete();
        add_pix(85, 100, 100, 1, 2);
        add_pix(80, 100, 100, 3, 4);
        add_pix(90, 100, 100, 5, 6);
        model(ex);
        send_frame(1'b1, fe);
        check_result("minc", fe, ex);
        chk("minc_cnt_const", last_r.cnt, 3);
        chk("minc_found_const", last_r.found, 0);

        set_win(0, 255, 0, 0, 1);
        pq.delete();
        add_pix(1, 1, 1, 3, 7);
        add_pix(2, 2, 2, 40, 9);
        add_pix(3, 3, 3, 15, 60);
        model(ex);
        send_frame(1'b1, fe);
        check_result("bbox", fe, ex);
`ifdef HSV_BLOB_BBOX_EN
        chk("bbox_xmin_const", last_r.bx0, 3);
        chk("bbox_xmax_const", last_r.bx1, 40);
        chk("bbox_ymin_const", last_r.by0, 7);
        chk("bbox_ymax_const", last_r.by1, 60);
`endif

        for (int f = 0; f < 12; f++) begin
            int n;
            set_win($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 6));
            pq.delete();
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) begin
                int hh, ss, vv;
                if ($urandom_range(0, 9) < 6)
                    hh = (int'(h_lo) + $urandom_range(0, (int'(h_hi) - int'(h_lo)) & 255)) & 255;
                else
                    hh = $urandom_range(0, 255);
                ss = ($urandom_range(0, 9) < 8) ? $urandom_range(int'(s_min), 255) : $urandom_range(0, 255);
                vv = ($urandom_range(0, 9) < 8) ? $urandom_range(int'(v_min), 255) : $urandom_range(0, 255);
                add_pix(hh, ss, vv, $urandom_range(0, 1023), $urandom_range(0, 767));
            end
            model(ex);
            send_frame(1'b1, fe);
            check_result($sformatf("rnd%0d", f), fe, ex);
        end

        // Second frame_end during the division must be dropped and flagged.
        set_win(80, 90, 50, 50, 1);
        pq.delete();
        add_pix(85, 100, 100, 100, 200);
        add_pix(86, 100, 100, 300, 400);
        add_pix(87, 100, 100, 501, 33);
        model(ex_a);
        send_frame(1'b0, fe_a);
        chk("ovr_pre", overrun, 0);
        while (edges < fe_a + 16) @(negedge clock);
        pq.delete();
        add_pix(85, 100, 100, 900, 700);
        add_pix(85, 100, 100, 901, 701);
        add_pix(85, 100, 100, 902, 702);
        add_pix(85, 100, 100, 903, 703);
        send_frame(1'b0, fe);
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", busy, 1);
        check_result("ovrA", fe_a, ex_a);
        repeat (120) @(negedge clock);
        chk("ovr_no_extra", rq.size(), 0);
        chk("ovr_sticky", overrun, 1);
        pq.delete();
        add_pix(84, 90, 90, 20, 30);
        add_pix(83, 90, 90, 40, 50);
        model(ex);
        send_frame(1'b1, fe);
        check_result("ovrC", fe, ex);

        // Reset in the middle of a division aborts it without a report.
        pq.delete();
        add_pix(85, 100, 100, 77, 88);
        add_pix(85, 100, 100, 79, 90);
        send_frame(1'b0, fe);
        while (edges < fe + 29) @(negedge clock);
        chk("mid_busy", busy, 1);
        chk("mid_cx_held", cx, last_r.cx);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("mid_rst_cx", cx, 0);
        chk("mid_rst_cy", cy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_found", found, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        repeat (100) @(negedge clock);
        chk("mid_no_result", rq.size(), 0);
        pq.delete();
        add_pix(85, 100, 100, 600, 10);
        add_pix(90, 100, 100, 601, 13);
        add_pix(80, 100, 100, 605, 20);
        model(ex);
        send_frame(1'b1, fe);
        check_result("post_rst", fe, ex);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
